// File: rtl/noc_input_fifo_if.sv
// noc_input_fifo_if: upstream write, downstream pop and status signals of the router input FIFO
interface noc_input_fifo_if #(parameter int FLIT_WIDTH = 32, parameter int DEPTH = 4);
  logic valid_in;
  logic [FLIT_WIDTH-1:0] flit_in;
  logic credit_out;
  logic rd_en;
  logic [FLIT_WIDTH-1:0] flit_out;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic empty;
  logic full;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  logic pkt_err;
  logic pkt_active;
  modport master (
    output valid_in, flit_in, rd_en,
    input  credit_out, flit_out, flit_id, dst_addr, empty, full, count, overflow, pkt_err, pkt_active
  );
  modport slave (
    input  valid_in, flit_in, rd_en,
    output credit_out, flit_out, flit_id, dst_addr, empty, full, count, overflow, pkt_err, pkt_active
  );
endinterface

// File: rtl/noc_input_fifo.sv
// noc_input_fifo: credit-flow-controlled FWFT flit buffer with read-side packet framing checker (INFIFO_PKT_CHECK_EN).
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif
module noc_input_fifo #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  noc_input_fifo_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic do_wr, do_rd, ovf, credit;
  assign do_wr = f.valid_in && !f.full;
  assign do_rd = f.rd_en && !f.empty;
  assign f.flit_out = mem[rd_ptr];
  assign f.flit_id = f.flit_out[FLIT_WIDTH-1 -: 3];
  assign f.dst_addr = f.flit_out[3:0];
  assign f.count = cnt;
  assign f.empty = cnt == '0;
  assign f.full = cnt == (AW+1)'(DEPTH);
  assign f.overflow = ovf;
  assign f.credit_out = credit;
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= f.flit_in;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      credit <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      if (f.valid_in && f.full) ovf <= 1'b1;
      credit <= do_rd;
    end
`ifdef INFIFO_PKT_CHECK_EN
  typedef enum logic {IDLE, BODY} state_t;
  state_t state, state_nx;
  logic err, err_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      err <= err_nx;
    end
  // an unexpected HEADER inside a packet is flagged but restarts the packet, so BODY is kept
  always_comb begin
    state_nx = state;
    err_nx = err;
    if (do_rd && state == IDLE) begin
      state_nx = f.flit_id == `HEADER ? BODY : IDLE;
      err_nx = err | (f.flit_id != `HEADER);
    end else if (do_rd) begin
      state_nx = f.flit_id == `TAIL ? IDLE : BODY;
      err_nx = err | (f.flit_id != `PAYLOAD && f.flit_id != `TAIL);
    end
  end
  assign f.pkt_err = err;
  assign f.pkt_active = state == BODY;
`else
  assign f.pkt_err = 1'b0;
  assign f.pkt_active = 1'b0;
`endif
endmodule

// File: tb/tb_noc_input_fifo.sv
// tb_noc_input_fifo: directed and randomized checks of noc_input_fifo against a queue-based reference model.
module tb_noc_input_fifo;
  localparam int W = 32;
  localparam int D = 4;
  localparam logic [2:0] H = 3'b001, P = 3'b010, T = 3'b100;
`ifdef INFIFO_PKT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  noc_input_fifo_if #(.FLIT_WIDTH(W), .DEPTH(D)) bus ();
  noc_input_fifo #(.FLIT_WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .f(bus.slave));
  always #5 clk = ~clk;
  logic [W-1:0] q[$];
  bit m_ovf, m_credit, m_err, m_in;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] mk(input logic [2:0] id, input logic [3:0] dst);
    logic [24:0] mid;
    mid = 25'($urandom);
    return {id, mid, dst};
  endfunction
  // reference model: the FIFO is a queue, framing is a single "inside a packet" flag
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ovf = 0;
      m_credit = 0;
      m_err = 0;
      m_in = 0;
    end else begin
      bit wr, rd;
      logic [2:0] id;
      wr = bus.valid_in && q.size() < D;
      rd = bus.rd_en && q.size() > 0;
      if (bus.valid_in && q.size() == D) m_ovf = 1;
      m_credit = rd;
      if (rd) begin
        id = q[0][W-1 -: 3];
        if (!m_in) begin
          if (id == H) m_in = 1; else m_err = 1;
        end else if (id == T) m_in = 0;
        else if (id != P) m_err = 1;
        void'(q.pop_front());
      end
      if (wr) q.push_back(bus.flit_in);
    end
  end
  always @(negedge clk) begin
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == D);
    chk("count", bus.count, q.size());
    chk("credit_out", bus.credit_out, m_credit);
    chk("overflow", bus.overflow, m_ovf);
    chk("pkt_err", bus.pkt_err, CHK && m_err);
    chk("pkt_active", bus.pkt_active, CHK && m_in);
    if (q.size() > 0) begin
      chk("flit_out", bus.flit_out, q[0]);
      chk("flit_id", bus.flit_id, q[0][W-1 -: 3]);
      chk("dst_addr", bus.dst_addr, q[0][3:0]);
    end
  end
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    #1;
    bus.valid_in = v;
    bus.flit_in = d;
    bus.rd_en = r;
    @(posedge clk);
    #1;
    bus.valid_in = 0;
    bus.rd_en = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask
  logic [W-1:0] a[8];
  logic [2:0] gid;
  bit g_in;
  initial begin
    bus.valid_in = 0;
    bus.flit_in = '0;
    bus.rd_en = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_credit", bus.credit_out, 0);
    rst = 1;
    cyc(1, mk(H, 4'hA), 0);
    cyc(1, mk(P, 4'h3), 0);
    cyc(1, mk(T, 4'h5), 0);
    chk("hpt_count", bus.count, 3);
    chk("hpt_id0", bus.flit_id, H);
    chk("hpt_dst", bus.dst_addr, 4'hA);
    cyc(0, '0, 1);
    chk("hpt_credit1", bus.credit_out, 1);
    chk("hpt_id1", bus.flit_id, P);
    chk("hpt_active", bus.pkt_active, CHK);
    cyc(0, '0, 1);
    chk("hpt_id2", bus.flit_id, T);
    cyc(0, '0, 1);
    chk("hpt_done_active", bus.pkt_active, 0);
    chk("hpt_err", bus.pkt_err, 0);
    cyc(0, '0, 0);
    chk("hpt_credit_end", bus.credit_out, 0);
    for (int i = 0; i < 5; i++) a[i] = mk(3'(i), 4'(i));
    for (int i = 0; i < 4; i++) cyc(1, a[i], 0);
    chk("full4", bus.full, 1);
    chk("count4", bus.count, 4);
    cyc(1, a[4], 1);
    chk("drop_count", bus.count, 3);
    chk("drop_ovf", bus.overflow, 1);
    chk("drop_head", bus.flit_out, a[1]);
    do_reset();
    for (int i = 0; i < 8; i++) a[i] = mk(P, 4'(i));
    cyc(1, a[0], 0);
    cyc(1, a[1], 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, a[(i + 2) % 8], 1);
      chk("rw_count", bus.count, 2);
      chk("rw_head", bus.flit_out, a[(i + 1) % 8]);
    end
    chk("rw_ovf", bus.overflow, 0);
    do_reset();
    cyc(1, mk(P, 4'h1), 1);
    cyc(0, '0, 1);
    chk("idle_payload_err", bus.pkt_err, CHK);
    do_reset();
    cyc(1, mk(H, 4'h1), 0);
    cyc(1, mk(H, 4'h2), 1);
    cyc(0, '0, 1);
    chk("hh_err", bus.pkt_err, CHK);
    chk("hh_active", bus.pkt_active, CHK);
    do_reset();
    cyc(1, mk(H, 4'h7), 0);
    cyc(1, mk(P, 4'h0), 0);
    cyc(1, mk(P, 4'h0), 0);
    cyc(1, mk(T, 4'h0), 1);
    chk("mid_count", bus.count, 3);
    @(negedge clk);
    #3;
    rst = 0;
    #1;
    chk("mid_empty", bus.empty, 1);
    chk("mid_count0", bus.count, 0);
    chk("mid_active", bus.pkt_active, 0);
    @(posedge clk);
    #1;
    rst = 1;
    cyc(1, mk(H, 4'hC), 0);
    chk("post_id", bus.flit_id, H);
    chk("post_dst", bus.dst_addr, 4'hC);
    cyc(0, '0, 1);
    chk("post_active", bus.pkt_active, CHK);
    chk("post_err", bus.pkt_err, 0);
    g_in = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) begin
        do_reset();
        g_in = 0;
      end
      if ($urandom_range(0, 19) == 0) gid = 3'($urandom);
      else gid = !g_in ? H : ($urandom_range(0, 2) == 0 ? T : P);
      if (bus.valid_in == 0 && $urandom_range(0, 9) < 6) begin
        if (!bus.full) g_in = gid == H ? 1 : (gid == T ? 0 : g_in);
        cyc(1, mk(gid, 4'($urandom)), $urandom_range(0, 9) < 5);
      end else cyc(0, '0, $urandom_range(0, 9) < 5);
    end
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
